// File: rtl/sddr_pkg.sv
// Shared DDR3 port-arbiter types and widths, common with the sddr_ctrl instantiation.
package sddr_pkg;

  localparam int unsigned SDDR_ADDR_BITS = 27;
  localparam int unsigned SDDR_DATA_BITS = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_RSP
  } arb_state_t;

  // Watchdog counter width; a disabled watchdog still needs one bit to exist.
  function automatic int unsigned wd_bits(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sddr_port_arbiter_if.sv
// Requester-side and controller-side signals of the DDR3 data-port arbiter.
interface sddr_port_arbiter_if import sddr_pkg::*; #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_BITS = SDDR_ADDR_BITS,
  parameter int unsigned DATA_BITS = SDDR_DATA_BITS
);
  logic [NUM_PORTS-1:0]           req_valid_i;
  logic [NUM_PORTS-1:0]           req_write_i;
  logic [NUM_PORTS*ADDR_BITS-1:0] req_addr_i;
  logic [NUM_PORTS*DATA_BITS-1:0] req_data_i;
  logic [NUM_PORTS-1:0]           req_ack_o;
  logic [NUM_PORTS-1:0]           rsp_valid_o;
  logic [NUM_PORTS-1:0]           rsp_err_o;
  logic [DATA_BITS-1:0]           rsp_data_o;
  logic                           data_cmd_valid;
  logic                           data_cmd_write;
  logic [ADDR_BITS-1:0]           data_cmd_address;
  logic [DATA_BITS-1:0]           data_cmd_data_o;
  logic                           data_cmd_ack;
  logic                           data_rsp_ready;
  logic [DATA_BITS-1:0]           data_rsp_data_i;
  logic                           busy_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_data_i,
    input  data_cmd_ack, data_rsp_ready, data_rsp_data_i,
    output req_ack_o, rsp_valid_o, rsp_err_o, rsp_data_o,
    output data_cmd_valid, data_cmd_write, data_cmd_address, data_cmd_data_o,
    output busy_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_data_i,
    output data_cmd_ack, data_rsp_ready, data_rsp_data_i,
    input  req_ack_o, rsp_valid_o, rsp_err_o, rsp_data_o,
    input  data_cmd_valid, data_cmd_write, data_cmd_address, data_cmd_data_o,
    input  busy_o
  );

endinterface

// File: rtl/sddr_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping.
module sddr_rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    logic [IDXW-1:0] j;
    j     = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      j = IDXW'((32'(ptr) + i) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/sddr_port_arbiter.sv
// Round-robin sharing of the DDR3 data command port, one outstanding command,
// read responses routed back to the owning port with a response watchdog.
module sddr_port_arbiter import sddr_pkg::*; #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned ADDR_BITS   = SDDR_ADDR_BITS,
  parameter int unsigned DATA_BITS   = SDDR_DATA_BITS,
  parameter int unsigned RSP_TIMEOUT = 1023
) (
  input logic               cpu_clock_i,
  input logic               reset_i,
  sddr_port_arbiter_if.slave bus
);

  localparam int unsigned     IDXW      = $clog2(NUM_PORTS);
  localparam int unsigned     WDW       = wd_bits(RSP_TIMEOUT);
  localparam logic [WDW-1:0]  WD_LAST   = WDW'(RSP_TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_PORT = IDXW'(NUM_PORTS - 1);

  arb_state_t            state;
  logic [IDXW-1:0]       rr_ptr;
  logic [IDXW-1:0]       owner;
  logic [NUM_PORTS-1:0]  owner_onehot;
  logic [NUM_PORTS-1:0]  pick_grant;
  logic [IDXW-1:0]       pick_idx;
  logic                  pick_any;
  logic                  cmd_write;
  logic [ADDR_BITS-1:0]  cmd_addr;
  logic [DATA_BITS-1:0]  cmd_data;
  logic [NUM_PORTS-1:0]  rsp_valid;
  logic [NUM_PORTS-1:0]  rsp_err;
  logic [DATA_BITS-1:0]  rsp_data;
  logic [WDW-1:0]        watchdog;

  sddr_rr_pick #(.N(NUM_PORTS)) u_pick (
    .req   (bus.req_valid_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign owner_onehot = NUM_PORTS'(1) << owner;

  // Grant is combinational so a requester transfers in the same cycle; reset masks it.
  assign bus.req_ack_o        = (state == ARB_IDLE && !reset_i) ? pick_grant : '0;
  assign bus.rsp_valid_o      = rsp_valid;
  assign bus.rsp_err_o        = rsp_err;
  assign bus.rsp_data_o       = rsp_data;
  assign bus.data_cmd_valid   = (state == ARB_ISSUE);
  assign bus.data_cmd_write   = cmd_write;
  assign bus.data_cmd_address = cmd_addr;
  assign bus.data_cmd_data_o  = cmd_data;
  assign bus.busy_o           = (state != ARB_IDLE);

  always_ff @(posedge cpu_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_data  <= '0;
      watchdog  <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            owner     <= pick_idx;
            cmd_write <= bus.req_write_i[pick_idx];
            cmd_addr  <= bus.req_addr_i[32'(pick_idx)*ADDR_BITS +: ADDR_BITS];
            cmd_data  <= bus.req_data_i[32'(pick_idx)*DATA_BITS +: DATA_BITS];
            rr_ptr    <= (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (bus.data_cmd_ack) begin
            if (cmd_write) begin
              state <= ARB_IDLE;
            end else begin
              watchdog <= '0;
              state    <= ARB_WAIT_RSP;
            end
          end
        end
        ARB_WAIT_RSP: begin
          // Arriving data takes priority over an expiring watchdog.
          if (bus.data_rsp_ready) begin
            rsp_data  <= bus.data_rsp_data_i;
            rsp_valid <= owner_onehot;
            state     <= ARB_IDLE;
          end else if (RSP_TIMEOUT != 0 && watchdog == WD_LAST) begin
            rsp_err <= owner_onehot;
            state   <= ARB_IDLE;
          end else if (watchdog != '1) begin
            watchdog <= watchdog + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sddr_port_arbiter.sv
// Randomized and directed bench for sddr_port_arbiter against a transaction-level model.
module tb_sddr_port_arbiter;
  import sddr_pkg::*;

  localparam int NP  = 4;
  localparam int AB  = 27;
  localparam int DB  = 128;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sddr_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  sddr_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .RSP_TIMEOUT(TMO)
  ) dut (
    .cpu_clock_i (clk),
    .reset_i     (rst),
    .bus         (bus)
  );

  int errors = 0;
  int checks = 0;

  // requester slots and controller stimulus
  logic [NP-1:0] s_valid, s_write;
  logic [AB-1:0] s_addr [NP];
  logic [DB-1:0] s_data [NP];
  logic          c_ack, c_rdy;
  logic [DB-1:0] c_rdata;

  // reference model
  int            m_ptr, m_owner, m_wait_cycles;
  bit            m_pending, m_waiting, m_write;
  logic [AB-1:0] m_addr;
  logic [DB-1:0] m_data, m_last_data;
  logic [NP-1:0] e_rsp_valid, e_rsp_err;

  logic [NP-1:0] ack_obs [$];
  logic [NP-1:0] rv_obs  [$];
  logic [NP-1:0] err_obs [$];
  logic [DB-1:0] rd_obs  [$];

  task automatic check_eq(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_first(input logic [NP-1:0] v, input int ptr);
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (ptr + k) % NP;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_wait_cycles = 0;
    m_pending = 0; m_waiting = 0; m_write = 0;
    m_addr = '0; m_data = '0; m_last_data = '0;
    e_rsp_valid = '0; e_rsp_err = '0;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.req_valid_i[p] = s_valid[p];
      bus.req_write_i[p] = s_write[p];
      bus.req_addr_i[p*AB +: AB] = s_addr[p];
      bus.req_data_i[p*DB +: DB] = s_data[p];
    end
    bus.data_cmd_ack    = c_ack;
    bus.data_rsp_ready  = c_rdy;
    bus.data_rsp_data_i = c_rdata;
  endtask

  task automatic new_req(input int p, input logic wr);
    s_valid[p] = 1'b1;
    s_write[p] = wr;
    s_addr[p]  = AB'($urandom);
    s_data[p]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic clear_obs();
    ack_obs.delete(); rv_obs.delete(); err_obs.delete(); rd_obs.delete();
  endtask

  // One clock: entered and left at posedge+1, outputs sampled at posedge+3.
  task automatic step();
    int g;
    logic [NP-1:0] exp_ack;
    drive();
    #2;
    g = -1;
    exp_ack = '0;
    if (m_owner < 0) begin
      g = rr_first(s_valid, m_ptr);
      if (g >= 0) exp_ack[g] = 1'b1;
    end
    check_eq("req_ack", bus.req_ack_o, exp_ack);
    check_eq("busy", bus.busy_o, m_owner >= 0);
    check_eq("cmd_valid", bus.data_cmd_valid, m_pending);
    if (m_pending) begin
      check_eq("cmd_write", bus.data_cmd_write, m_write);
      check_eq("cmd_addr", bus.data_cmd_address, m_addr);
      check_eq("cmd_data", bus.data_cmd_data_o, m_data);
    end
    check_eq("rsp_valid", bus.rsp_valid_o, e_rsp_valid);
    check_eq("rsp_err", bus.rsp_err_o, e_rsp_err);
    check_eq("rsp_data", bus.rsp_data_o, m_last_data);
    if (bus.req_ack_o != '0) ack_obs.push_back(bus.req_ack_o);
    if (bus.rsp_valid_o != '0) begin
      rv_obs.push_back(bus.rsp_valid_o);
      rd_obs.push_back(bus.rsp_data_o);
    end
    if (bus.rsp_err_o != '0) err_obs.push_back(bus.rsp_err_o);

    e_rsp_valid = '0;
    e_rsp_err   = '0;
    if (g >= 0) begin
      m_owner   = g;
      m_ptr     = (g + 1) % NP;
      m_pending = 1;
      m_write   = s_write[g];
      m_addr    = s_addr[g];
      m_data    = s_data[g];
      s_valid[g] = 1'b0;
    end else if (m_pending) begin
      if (c_ack) begin
        m_pending = 0;
        if (m_write) m_owner = -1;
        else begin
          m_waiting = 1;
          m_wait_cycles = 0;
        end
      end
    end else if (m_waiting) begin
      m_wait_cycles++;
      if (c_rdy) begin
        e_rsp_valid[m_owner] = 1'b1;
        m_last_data = c_rdata;
        m_waiting = 0; m_owner = -1;
      end else if (TMO != 0 && m_wait_cycles == TMO) begin
        e_rsp_err[m_owner] = 1'b1;
        m_waiting = 0; m_owner = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive();
    rst = 1'b1;
    #1;
    check_eq("rst_ack", bus.req_ack_o, '0);
    check_eq("rst_busy", bus.busy_o, '0);
    check_eq("rst_cmd_valid", bus.data_cmd_valid, '0);
    check_eq("rst_cmd_write", bus.data_cmd_write, '0);
    check_eq("rst_cmd_addr", bus.data_cmd_address, '0);
    check_eq("rst_cmd_data", bus.data_cmd_data_o, '0);
    check_eq("rst_rsp_valid", bus.rsp_valid_o, '0);
    check_eq("rst_rsp_err", bus.rsp_err_o, '0);
    check_eq("rst_rsp_data", bus.rsp_data_o, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    c_ack = 1'b0;
    c_rdy = 1'b0;
  endtask

  initial begin
    s_valid = '0; s_write = '0;
    for (int p = 0; p < NP; p++) begin
      s_addr[p] = '0;
      s_data[p] = '0;
    end
    c_ack = 1'b0; c_rdy = 1'b0; c_rdata = '0;
    model_reset();
    #1;
    do_reset();

    // Ports 0 and 2 read together: port 0 first, then port 2.
    clear_obs();
    new_req(0, 1'b0);
    new_req(2, 1'b0);
    c_ack = 1'b1;
    for (int n = 0; n < 40 && rv_obs.size() < 2; n++) begin
      c_rdy   = m_waiting;
      c_rdata = (rv_obs.size() == 0) ? {16{8'hA5}} : {16{8'h5A}};
      step();
    end
    c_rdy = 1'b0;
    check_eq("rd2_count", rv_obs.size(), 2);
    if (rv_obs.size() >= 2) begin
      check_eq("rd2_first_port", rv_obs[0], 4'b0001);
      check_eq("rd2_first_data", rd_obs[0], {16{8'hA5}});
      check_eq("rd2_second_port", rv_obs[1], 4'b0100);
      check_eq("rd2_second_data", rd_obs[1], {16{8'h5A}});
    end

    // All ports write continuously with an always-ready controller.
    do_reset();
    clear_obs();
    c_ack = 1'b1;
    for (int n = 0; n < 10; n++) begin
      for (int p = 0; p < NP; p++) if (!s_valid[p]) new_req(p, 1'b1);
      step();
    end
    check_eq("wr_grant_count", ack_obs.size(), 5);
    if (ack_obs.size() >= 5) begin
      check_eq("wr_grant0", ack_obs[0], 4'b0001);
      check_eq("wr_grant1", ack_obs[1], 4'b0010);
      check_eq("wr_grant2", ack_obs[2], 4'b0100);
      check_eq("wr_grant3", ack_obs[3], 4'b1000);
      check_eq("wr_grant4", ack_obs[4], 4'b0001);
    end
    check_eq("wr_no_rsp", rv_obs.size() + err_obs.size(), 0);

    // Controller stalls its accept for 50 cycles.
    do_reset();
    s_valid = '0;
    new_req(1, 1'b1);
    step();
    for (int p = 0; p < NP; p++) if (!s_valid[p]) new_req(p, $urandom_range(0, 1));
    clear_obs();
    for (int n = 0; n < 50; n++) step();
    check_eq("stall_no_ack", ack_obs.size(), 0);
    c_ack = 1'b1;
    for (int n = 0; n < 4; n++) step();

    // Unanswered read times out; late data is dropped.
    do_reset();
    s_valid = '0;
    clear_obs();
    new_req(3, 1'b0);
    c_ack = 1'b1;
    for (int n = 0; n < 25; n++) step();
    c_rdy = 1'b1;
    c_rdata = {$urandom, $urandom, $urandom, $urandom};
    step();
    c_rdy = 1'b0;
    step();
    step();
    check_eq("tmo_err_count", err_obs.size(), 1);
    if (err_obs.size() >= 1) check_eq("tmo_err_port", err_obs[0], 4'b1000);
    check_eq("tmo_no_valid", rv_obs.size(), 0);

    // Data arriving in the watchdog's final cycle wins.
    do_reset();
    s_valid = '0;
    clear_obs();
    new_req(0, 1'b0);
    c_ack = 1'b1;
    c_rdata = {4{32'hC0FFEE11}};
    for (int n = 0; n < 40 && rv_obs.size() + err_obs.size() == 0; n++) begin
      c_rdy = m_waiting && (m_wait_cycles == TMO - 1);
      step();
    end
    c_rdy = 1'b0;
    check_eq("race_valid_count", rv_obs.size(), 1);
    check_eq("race_err_count", err_obs.size(), 0);
    if (rv_obs.size() >= 1) begin
      check_eq("race_port", rv_obs[0], 4'b0001);
      check_eq("race_data", rd_obs[0], {4{32'hC0FFEE11}});
    end

    // Reset while waiting for read data; the late response is dropped.
    do_reset();
    s_valid = '0;
    clear_obs();
    new_req(1, 1'b0);
    c_ack = 1'b1;
    for (int n = 0; n < 10 && !m_waiting; n++) step();
    check_eq("midrst_waiting", bus.busy_o, 1'b1);
    step();
    step();
    new_req(3, 1'b1);
    do_reset();
    c_rdy = 1'b1;
    c_rdata = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 3; n++) step();
    c_rdy = 1'b0;
    check_eq("midrst_no_valid", rv_obs.size(), 0);
    check_eq("midrst_no_err", err_obs.size(), 0);

    // Random traffic.
    do_reset();
    s_valid = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int p = 0; p < NP; p++) begin
        if (s_valid[p] && $urandom_range(0, 15) == 0) s_valid[p] = 1'b0;
        else if (!s_valid[p] && $urandom_range(0, 2) == 0) new_req(p, $urandom_range(0, 1));
      end
      c_ack   = $urandom_range(0, 1);
      c_rdy   = ($urandom_range(0, 9) == 0);
      c_rdata = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
